// File: rtl/fetch_stage_if.sv
// Handshake/bus bundle between the fetch stage and its neighbours:
// the ROM, the decode stage and the branch resolution logic.
interface fetch_stage_if #(
  parameter int AW = 5,
  parameter int IW = 32
);
  logic [AW-1:0] pc;
  logic [IW-1:0] instr_in;
  logic          stall;
  logic          pc_src;
  logic [IW-1:0] imm_ext;
  logic [IW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic          id_valid;

  modport master (
    output pc, id_instr, id_pc, id_valid,
    input  instr_in, stall, pc_src, imm_ext
  );

  modport slave (
    input  pc, id_instr, id_pc, id_valid,
    output instr_in, stall, pc_src, imm_ext
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, registers ROM data into IF/ID, and
// handles decode stalls and taken-branch redirects with a one-bubble flush.
module fetch_stage #(
  parameter int INSTRUCTION_ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter logic [INSTRUCTION_ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter logic [4*DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);
  localparam int AW = INSTRUCTION_ADDRESS_WIDTH;
  localparam int IW = 4 * DATA_WIDTH;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] id_pc_q, id_pc_d;
  logic [IW-1:0] id_instr_q, id_instr_d;
  logic          id_valid_q, id_valid_d;
  logic          redirect;
  logic [AW-1:0] branch_sum;
  logic [AW-1:0] target;
  logic          unused_imm_high;

  // A branch only counts when the instruction sitting in IF/ID is real.
  assign redirect   = bus.pc_src && id_valid_q;
  assign branch_sum = id_pc_q + bus.imm_ext[AW-1:0];
  assign target     = {branch_sum[AW-1:2], 2'b00};
  assign unused_imm_high = ^bus.imm_ext[IW-1:AW];

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (redirect) begin
      pc_d       = target;
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d       = pc_q + AW'(4);
      id_instr_d = bus.instr_in;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.id_instr = id_instr_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_valid = id_valid_q;
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the byte-addressed instruction ROM.
- Owns the program counter and drives the ROM address.
- Takes the combinational 32-bit instruction word back from the ROM and registers it with its PC into an IF/ID pipeline register for the decode stage.
- Handles decode-stage stalls and taken-branch redirects, including flushing the wrong-path fetch.

Parameters:
- INSTRUCTION_ADDRESS_WIDTH, 5, PC / ROM byte-address width (AW).
- DATA_WIDTH, 8, ROM byte width; instruction width is 4*DATA_WIDTH (32).
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.
- NOP_INSTR, 32'h00000013, bubble instruction inserted on reset and flush.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pc  output  AW  current fetch address; connects to the ROM address input
- instr_in  input  4*DATA_WIDTH  ROM data for address pc, valid in the same cycle
- stall  input  1  decode requests hold; freezes pc and the IF/ID register
- pc_src  input  1  branch or jump taken, resolved in decode for the instruction in IF/ID
- imm_ext  input  4*DATA_WIDTH  sign-extended branch offset for the instruction in IF/ID
- id_instr  output  4*DATA_WIDTH  registered instruction to decode
- id_pc  output  AW  registered PC of id_instr
- id_valid  output  1  id_instr is a real fetched instruction, not a bubble

Behaviour:
- Reset values (rst=1 at a clock edge): pc=RESET_PC, id_instr=NOP_INSTR, id_pc=0, id_valid=0.
  - rst overrides every other input.
  - Reset asserted mid-stall or mid-redirect discards that operation.
- pc is a register driven straight onto the ROM address with no combinational path from inputs.
  - instr_in is therefore consumed in the same cycle; fetch-to-decode latency is 1 cycle.
- Redirect is taken only when pc_src=1 AND id_valid=1.
  - pc_src with id_valid=0 is ignored, and the cycle is treated as normal or stall.
- Per-edge priority: rst > redirect > stall > normal.
- Normal (stall=0, no redirect):
  - pc <= pc + 4, modulo 2^AW (wraps to 0).
  - id_instr <= instr_in, id_pc <= pc, id_valid <= 1.
- Stall (stall=1, no redirect): pc, id_instr, id_pc and id_valid all hold their values.
- Redirect:
  - pc <= target, where target = (id_pc + imm_ext[AW-1:0]) mod 2^AW with bits [1:0] forced to 0.
  - Flush: id_instr <= NOP_INSTR, id_valid <= 0; id_pc holds.
  - Redirect wins over a simultaneous stall: the branch instruction leaves decode and the wrong-path fetch is killed.
- Arithmetic:
  - All PC arithmetic is AW bits wide, unsigned, and truncating.
  - Only the low AW bits of imm_ext are used, so negative offsets work by two's-complement wrap.
- Steady-state throughput: one instruction per cycle; a taken branch costs exactly one bubble cycle.
- No state machine beyond the pc and IF/ID registers.
  - The id_valid bit acts as a two-state flag: BUBBLE (0) and VALID (1).
  - BUBBLE -> VALID on a normal cycle; any state -> BUBBLE on redirect or reset; stall holds the state.

Test Plan:
- Reset then run with a ROM image of words 0x11111111 at 0, 0x22222222 at 4 -> cycle 0 after reset: pc=0, id_valid=0, id_instr=0x00000013. Cycle 1: pc=4, id_instr=0x11111111, id_pc=0, id_valid=1. Cycle 2: id_instr=0x22222222, id_pc=4.
- Run free for 8 cycles with AW=5 -> pc sequence 0, 4, …, 28, 0; wrap-around is seamless and id_pc follows one cycle behind.
- Hold stall=1 for 3 cycles while id_pc=8 -> pc=12 and id_pc=8 stay fixed, id_instr unchanged; on release, pc=16 and id_pc=12 on the next edge.
- With id_pc=8, id_valid=1, pc_src=1, imm_ext=0xFFFFFFF8 (-8) -> next edge: pc=0, id_valid=0, id_instr=0x00000013. The following edge: id_instr=ROM[0], id_pc=0.
- With pc_src=1 and stall=1 together at id_pc=4, imm_ext=0x0000000E -> pc=16 (18 with low bits cleared), flush occurs, stall ignored.
- Assert pc_src=1 while id_valid=0 (right after reset) -> no redirect, pc advances 0->4. Also assert rst during a stall -> pc=RESET_PC, id_valid=0 on that edge.
